acs_sched: RTL and testbench

Time-multiplexed scheduler for the shared add-compare-select unit of the pipelined Viterbi decoder (constraint length 3, 4 trellis states, 2-bit received symbols, 7-bit path metrics).
- Accepts one received symbol per handshake and sequences the single combinational ACS instance through all four states.
- Captures the new path metrics, normalizes them, and streams survivor decisions to the traceback memory.
- Sits between the symbol input FIFO and the survivor/traceback stage.

---
 rtl/acs_sched_if.sv | 44 ++++
 rtl/acs_sched.sv | 150 +++++++++++++++
 tb/tb_acs_sched.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/acs_sched_if.sv
// Bundle of the scheduler's symbol input, ACS, survivor and status signals.
// master = scheduler side, slave = surrounding datapath (FIFO, ACS, traceback).
interface acs_sched_if;
  logic       start;
  logic       sym_valid;
  logic [1:0] sym_data;
  logic       sym_ready;

  logic       acs_en;
  logic [1:0] acs_state;
  logic [1:0] acs_data;
  logic [1:0] acs_addr1;
  logic [1:0] acs_addr2;
  logic [6:0] acs_pm1;
  logic [6:0] acs_pm2;
  logic [6:0] acs_pm_in;
  logic [1:0] acs_addr_in;
  logic       acs_rdy;
  logic       acs_dec;

  logic       surv_valid;
  logic [1:0] surv_state;
  logic [1:0] surv_prev;
  logic       surv_dec;

  logic       step_done;
  logic [1:0] best_state;
  logic [6:0] best_pm;
  logic       err;

  modport master (
    input  start, sym_valid, sym_data, acs_pm_in, acs_addr_in, acs_rdy, acs_dec,
    output sym_ready, acs_en, acs_state, acs_data, acs_addr1, acs_addr2,
           acs_pm1, acs_pm2, surv_valid, surv_state, surv_prev, surv_dec,
           step_done, best_state, best_pm, err
  );

  modport slave (
    output start, sym_valid, sym_data, acs_pm_in, acs_addr_in, acs_rdy, acs_dec,
    input  sym_ready, acs_en, acs_state, acs_data, acs_addr1, acs_addr2,
           acs_pm1, acs_pm2, surv_valid, surv_state, surv_prev, surv_dec,
           step_done, best_state, best_pm, err
  );
endinterface

// File: rtl/acs_sched.sv
// Time-multiplexed scheduler for the shared Viterbi ACS unit (K=3, 4 states).
// One symbol per step: CALC0..CALC3 run the ACS once per state, COMMIT
// normalizes the new metrics against their minimum and stores them.

// Per-state normalization: subtract the step minimum, clamp to PM_SAT.
module acs_sched_norm #(
  parameter logic [6:0] PM_SAT = 7'd125
) (
  input  logic [6:0] pm,
  input  logic [6:0] pm_min,
  output logic [6:0] pm_out
);
  logic [6:0] diff;
  // pm_min is the minimum of the set pm belongs to, so this never underflows
  assign diff   = pm - pm_min;
  assign pm_out = (diff > PM_SAT) ? PM_SAT : diff;
endmodule

module acs_sched #(
  parameter logic [6:0] PM_INIT = 7'd32,
  parameter logic [6:0] PM_SAT  = 7'd125
) (
  input  logic       clk,
  input  logic       rst_n,
  acs_sched_if.master bus
);
  localparam int NUM_ST = 4;
  localparam logic [NUM_ST-1:0][6:0] PM_RESET = {PM_INIT, PM_INIT, PM_INIT, 7'd0};

  typedef enum logic [2:0] {IDLE, CALC0, CALC1, CALC2, CALC3, COMMIT} st_t;

  st_t                     state_q, state_d;
  logic [1:0]              sym_q;
  logic [NUM_ST-1:0][6:0]  old_pm;
  logic [NUM_ST-1:0][6:0]  new_pm;
  logic [NUM_ST-1:0][6:0]  norm_pm;
  logic                    err_q;
  logic [1:0]              best_state_q;
  logic [6:0]              best_pm_q;

  logic                    is_calc;
  logic [1:0]              k;
  logic [1:0]              min_idx;
  logic [6:0]              min_pm;

  // Decode which trellis state the current CALC cycle serves
  always_comb begin
    is_calc = 1'b1;
    k       = 2'd0;
    case (state_q)
      CALC0:   k = 2'd0;
      CALC1:   k = 2'd1;
      CALC2:   k = 2'd2;
      CALC3:   k = 2'd3;
      default: is_calc = 1'b0;
    endcase
  end

  // Lowest new metric; strict compare keeps the lower index on ties
  always_comb begin
    min_idx = 2'd0;
    min_pm  = new_pm[0];
    for (int i = 1; i < NUM_ST; i++) begin
      if (new_pm[i] < min_pm) begin
        min_idx = 2'(i);
        min_pm  = new_pm[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_ST; g++) begin : g_norm
    acs_sched_norm #(.PM_SAT(PM_SAT)) u_norm (
      .pm     (new_pm[g]),
      .pm_min (min_pm),
      .pm_out (norm_pm[g])
    );
  end

  // Next state and all combinational outputs; ACS/survivor buses idle at 0
  always_comb begin
    state_d        = state_q;
    bus.sym_ready  = 1'b0;
    bus.acs_en     = 1'b0;
    bus.acs_state  = 2'd0;
    bus.acs_data   = 2'd0;
    bus.acs_addr1  = 2'd0;
    bus.acs_addr2  = 2'd0;
    bus.acs_pm1    = 7'd0;
    bus.acs_pm2    = 7'd0;
    bus.surv_valid = 1'b0;
    bus.surv_state = 2'd0;
    bus.surv_prev  = 2'd0;
    bus.surv_dec   = 1'b0;
    bus.step_done  = 1'b0;
    if (is_calc) begin
      // predecessors of state k are {k[0],0} and {k[0],1}
      bus.acs_en     = 1'b1;
      bus.acs_state  = k;
      bus.acs_data   = sym_q;
      bus.acs_addr1  = {k[0], 1'b0};
      bus.acs_addr2  = {k[0], 1'b1};
      bus.acs_pm1    = old_pm[{k[0], 1'b0}];
      bus.acs_pm2    = old_pm[{k[0], 1'b1}];
      bus.surv_valid = 1'b1;
      bus.surv_state = k;
      bus.surv_prev  = bus.acs_addr_in;
      bus.surv_dec   = bus.acs_dec;
      state_d        = (k == 2'd3) ? COMMIT : st_t'(state_q + 3'd1);
    end else if (state_q == COMMIT) begin
      bus.step_done = 1'b1;
      state_d       = IDLE;
    end else begin
      // start wins over a simultaneous symbol, so hide ready while it is up
      bus.sym_ready = !bus.start;
      if (!bus.start && bus.sym_valid) state_d = CALC0;
    end
  end

  // State, symbol latch, metric banks, sticky error and best-state report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sym_q        <= 2'd0;
      old_pm       <= PM_RESET;
      new_pm       <= '0;
      err_q        <= 1'b0;
      best_state_q <= 2'd0;
      best_pm_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      if (is_calc) begin
        new_pm[k] <= bus.acs_pm_in;
        if (!bus.acs_rdy) err_q <= 1'b1;
      end else if (state_q == COMMIT) begin
        old_pm       <= norm_pm;
        best_state_q <= min_idx;
        best_pm_q    <= min_pm;
      end else if (bus.start) begin
        old_pm <= PM_RESET;
        err_q  <= 1'b0;
      end else if (bus.sym_valid) begin
        sym_q <= bus.sym_data;
      end
    end
  end

  assign bus.err        = err_q;
  assign bus.best_state = best_state_q;
  assign bus.best_pm    = best_pm_q;
endmodule

// File: tb/tb_acs_sched.sv
// Directed bench for acs_sched with a behavioural ACS: either a real K=3
// (7,5) add-compare-select or a table returning fixed metrics per state.
module tb_acs_sched;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  acs_sched_if bus ();
  acs_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic       real_mode;
  logic [3:0] rdy_mask;
  logic [6:0] tbl [4];
  logic [6:0] m1, m2;

  logic [6:0] seen_pm   [4];
  logic [1:0] seen_prev [4];
  logic       seen_dec  [4];

  // encoder outputs for a transition out of state s with input bit u
  function automatic logic [1:0] lbl(input logic [1:0] s, input logic u);
    return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

  function automatic logic [1:0] ham(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  // ACS model
  always_comb begin
    m1 = bus.acs_pm1 + {5'd0, ham(lbl(bus.acs_addr1, bus.acs_state[1]), bus.acs_data)};
    m2 = bus.acs_pm2 + {5'd0, ham(lbl(bus.acs_addr2, bus.acs_state[1]), bus.acs_data)};
    bus.acs_rdy = rdy_mask[bus.acs_state];
    if (real_mode) begin
      if (m1 < m2) begin
        bus.acs_pm_in   = m1;
        bus.acs_addr_in = bus.acs_addr1;
      end else begin
        bus.acs_pm_in   = m2;
        bus.acs_addr_in = bus.acs_addr2;
      end
      bus.acs_dec = bus.acs_state[1];
    end else begin
      bus.acs_pm_in   = tbl[bus.acs_state];
      bus.acs_addr_in = bus.acs_state;
      bus.acs_dec     = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pm(input string tag, input int e0, input int e1, input int e2, input int e3);
    chk({tag, "_pm0"}, 32'(seen_pm[0]), e0);
    chk({tag, "_pm1"}, 32'(seen_pm[1]), e1);
    chk({tag, "_pm2"}, 32'(seen_pm[2]), e2);
    chk({tag, "_pm3"}, 32'(seen_pm[3]), e3);
  endtask

  task automatic chk_best(input string tag, input int st, input int pm);
    chk({tag, "_best_state"}, 32'(bus.best_state), st);
    chk({tag, "_best_pm"}, 32'(bus.best_pm), pm);
  endtask

  // One full step from a negedge in IDLE to the negedge at T+6.
  // Old metrics are observed on acs_pm1/acs_pm2 during CALC0/CALC1.
  task automatic run_step(input string tag, input logic [1:0] sym, input int start_at);
    int n;
    n = 0;
    while (!bus.sym_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_wait"}, 32'(bus.sym_ready), 1);
    bus.sym_valid = 1'b1;
    bus.sym_data  = sym;
    @(posedge clk);
    #1;
    bus.sym_valid = 1'b0;
    bus.sym_data  = ~sym;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = (i == start_at);
      chk($sformatf("%s_surv_valid%0d", tag, i), 32'(bus.surv_valid), 1);
      chk($sformatf("%s_surv_state%0d", tag, i), 32'(bus.surv_state), i);
      seen_prev[i] = bus.surv_prev;
      seen_dec[i]  = bus.surv_dec;
      if (i == 0) begin
        seen_pm[0] = bus.acs_pm1;
        seen_pm[1] = bus.acs_pm2;
      end else if (i == 1) begin
        seen_pm[2] = bus.acs_pm1;
        seen_pm[3] = bus.acs_pm2;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_step_done"}, 32'(bus.step_done), 1);
    chk({tag, "_ready_commit"}, 32'(bus.sym_ready), 0);
    @(negedge clk);
    chk({tag, "_step_done_off"}, 32'(bus.step_done), 0);
    chk({tag, "_ready_back"}, 32'(bus.sym_ready), 1);
  endtask

  initial begin
    rst_n         = 1'b0;
    real_mode     = 1'b1;
    rdy_mask      = 4'b1111;
    tbl           = '{7'd0, 7'd0, 7'd0, 7'd0};
    bus.start     = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym_data  = 2'd0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_sym_ready", 32'(bus.sym_ready), 1);
    chk("rst_acs_en", 32'(bus.acs_en), 0);
    chk("rst_surv_valid", 32'(bus.surv_valid), 0);
    chk("rst_step_done", 32'(bus.step_done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk_best("rst", 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // start together with a symbol: start wins, symbol not taken
    bus.start     = 1'b1;
    bus.sym_valid = 1'b1;
    bus.sym_data  = 2'b11;
    #1;
    chk("start_sym_ready", 32'(bus.sym_ready), 0);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.sym_valid = 1'b0;
    chk("start_no_step", 32'(bus.acs_en), 0);

    // real ACS, symbol 00 (sym_data flips after handshake)
    run_step("real00", 2'b00, -1);
    chk_pm("real00", 0, 32, 32, 32);
    chk("real00_prev0", 32'(seen_prev[0]), 0);
    chk("real00_prev1", 32'(seen_prev[1]), 3);
    chk("real00_prev2", 32'(seen_prev[2]), 0);
    chk("real00_prev3", 32'(seen_prev[3]), 3);
    chk("real00_dec0", 32'(seen_dec[0]), 0);
    chk("real00_dec1", 32'(seen_dec[1]), 0);
    chk("real00_dec2", 32'(seen_dec[2]), 1);
    chk("real00_dec3", 32'(seen_dec[3]), 1);
    chk_best("real00", 0, 0);
    chk("real00_err", 32'(bus.err), 0);

    // table 40,50,45,60
    real_mode = 1'b0;
    tbl = '{7'd40, 7'd50, 7'd45, 7'd60};
    run_step("tblA", 2'b01, -1);
    chk_pm("tblA", 0, 33, 2, 33);
    chk_best("tblA", 0, 40);

    // table 60,40,40,90: tie between 1 and 2 goes to 1
    tbl = '{7'd60, 7'd40, 7'd40, 7'd90};
    run_step("tblB", 2'b10, -1);
    chk_pm("tblB", 0, 10, 5, 20);
    chk_best("tblB", 1, 40);

    // saturation step, start raised during CALC1 must be ignored
    tbl = '{7'd0, 7'd127, 7'd127, 7'd127};
    run_step("satC", 2'b11, 1);
    chk_pm("satC", 20, 0, 0, 50);
    chk_best("satC", 0, 0);

    // acs_rdy low in CALC2
    tbl = '{7'd0, 7'd0, 7'd0, 7'd0};
    rdy_mask = 4'b1011;
    run_step("rdyD", 2'b00, -1);
    chk_pm("rdyD", 0, 125, 125, 125);
    chk("rdyD_err", 32'(bus.err), 1);

    // err is sticky across a clean step; all-equal ties pick state 0
    rdy_mask = 4'b1111;
    tbl = '{7'd5, 7'd5, 7'd5, 7'd5};
    run_step("stkE", 2'b00, -1);
    chk_pm("stkE", 0, 0, 0, 0);
    chk("stkE_err", 32'(bus.err), 1);
    chk_best("stkE", 0, 5);

    // start alone in IDLE clears err and reinitializes metrics
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("clr_err", 32'(bus.err), 0);
    real_mode = 1'b1;
    run_step("realF", 2'b00, -1);
    chk_pm("realF", 0, 32, 32, 32);
    chk_best("realF", 0, 0);

    real_mode = 1'b0;
    tbl = '{7'd9, 7'd7, 7'd9, 7'd9};
    run_step("tblG", 2'b00, -1);
    chk_pm("tblG", 0, 33, 2, 33);
    chk_best("tblG", 1, 7);

    // reset pulsed in CALC2
    bus.sym_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.sym_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_in_calc2", 32'(bus.surv_state), 2);
    rst_n = 1'b0;
    #1;
    chk("rstmid_surv_valid", 32'(bus.surv_valid), 0);
    chk("rstmid_acs_en", 32'(bus.acs_en), 0);
    chk("rstmid_sym_ready", 32'(bus.sym_ready), 1);
    chk_best("rstmid", 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid_no_done%0d", i), 32'(bus.step_done), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid_idle%0d", i), 32'({bus.surv_valid, bus.step_done}), 0);
    end
    run_step("post", 2'b00, -1);
    chk_pm("post", 0, 32, 32, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
